// File: rtl/rete_multireg_seq.sv
// Register-file datapath with a single-cycle multi-op ALU and a multi-cycle shift-add
// multiplier behind a ready/valid handshake; out shows any register combinationally.
module rete_multireg_seq #(
    parameter int N = 8,
    parameter int R = 4,
    localparam int LR = $clog2(R)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [N-1:0]  x,
    input  logic [N-1:0]  y,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    aluop,
    input  logic [LR-1:0] sel_a,
    input  logic          use_x,
    input  logic [LR-1:0] sel_b,
    input  logic          use_y,
    input  logic [LR-1:0] dst,
    input  logic [LR-1:0] rd_sel,
    output logic [N-1:0]  out,
    output logic          zero,
    output logic          carry,
    output logic          done
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [N-1:0]    regs [R];
    logic [N-1:0]    opa, opb;
    logic [N:0]      alu;
    logic [2*N-1:0]  mcand, acc, acc_next;
    logic [N-1:0]    mplier;
    logic [CW-1:0]   cnt;
    logic [LR-1:0]   mul_dst;
    logic            last_step;

    always_comb begin
        opa = use_x ? x : regs[sel_a];
        opb = use_y ? y : regs[sel_b];
        alu = '0;
        case (aluop)
            3'd0:    alu = {1'b0, opa} + {1'b0, opb};
            3'd1:    alu = {1'b0, opa} - {1'b0, opb};  // bit N is the borrow
            3'd2:    alu = {1'b0, opa & opb};
            3'd3:    alu = {1'b0, opa | opb};
            3'd4:    alu = {1'b0, opa ^ opb};
            3'd5:    alu = {1'b0, opa};
            3'd6:    alu = {opa, 1'b0};
            default: alu = '0;
        endcase
    end

    // One shift-add step per BUSY cycle, LSB of the multiplier first.
    always_comb begin
        acc_next  = acc + (mplier[0] ? mcand : '0);
        last_step = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            for (int unsigned i = 0; i < R; i++) regs[i] <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            done    <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            mul_dst <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (aluop == 3'd7) begin
                            mcand   <= {{N{1'b0}}, opa};
                            mplier  <= opb;
                            acc     <= '0;
                            cnt     <= '0;
                            mul_dst <= dst;
                            state   <= BUSY;
                        end else begin
                            regs[dst] <= alu[N-1:0];
                            zero      <= (alu[N-1:0] == '0);
                            carry     <= alu[N];
                        end
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        regs[mul_dst] <= acc_next[N-1:0];
                        zero          <= (acc_next[N-1:0] == '0);
                        carry         <= (acc_next[2*N-1:N] != '0);
                        done          <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign op_ready = (state == IDLE);
    assign out      = regs[rd_sel];
endmodule

// File: tb/tb_rete_multireg_seq.sv
// Scoreboard bench for rete_multireg_seq: a reference model pushes the expected
// write-back per operation and the result is popped and compared once the DUT writes it.
module tb_rete_multireg_seq;
    localparam int N = 8;
    localparam int R = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] x = '0, y = '0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [2:0] aluop = '0;
    logic [1:0] sel_a = '0, sel_b = '0, dst = '0, rd_sel = '0;
    logic       use_x = 1'b0, use_y = 1'b0;
    logic [7:0] out;
    logic       zero, carry, done;

    rete_multireg_seq #(.N(N), .R(R)) dut (
        .clock(clock), .reset_n(reset_n), .x(x), .y(y),
        .op_valid(op_valid), .op_ready(op_ready), .aluop(aluop),
        .sel_a(sel_a), .use_x(use_x), .sel_b(sel_b), .use_y(use_y),
        .dst(dst), .rd_sel(rd_sel), .out(out),
        .zero(zero), .carry(carry), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] d;
        logic [7:0] val;
        logic       z;
        logic       c;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_reg[R];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ref_alu(input int op, input int a, input int b);
        int r;
        int c;
        r = 0;
        c = 0;
        case (op)
            0: begin r = a + b; c = (r > 255) ? 1 : 0; end
            1: begin r = a - b; c = (a < b) ? 1 : 0; if (r < 0) r += 256; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a;
            6: begin r = a * 2; c = (a >= 128) ? 1 : 0; end
            default: begin r = a * b; c = (r > 255) ? 1 : 0; end
        endcase
        return {c[0], 8'(r & 255)};
    endfunction

    task automatic check_all_regs(input string tag, input logic [7:0] exp_v[R]);
        for (int i = 0; i < R; i++) begin
            rd_sel = 2'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), out, exp_v[i]);
        end
    endtask

    task automatic do_op(input string tag, input int op, input bit ux, input int xv, input int sa,
                         input bit uy, input int yv, input int sbi, input int d, input bit disturb);
        int         a, b, low, cyc;
        logic [8:0] r;
        exp_t       e;
        @(negedge clock);
        aluop = 3'(op); use_x = ux; x = 8'(xv); sel_a = 2'(sa);
        use_y = uy; y = 8'(yv); sel_b = 2'(sbi); dst = 2'(d); op_valid = 1'b1;
        a = ux ? xv : int'(m_reg[sa]);
        b = uy ? yv : int'(m_reg[sbi]);
        r = ref_alu(op, a, b);
        e.d = 2'(d); e.val = r[7:0]; e.z = (r[7:0] == 8'd0); e.c = r[8];
        sb.push_back(e);
        m_reg[d] = r[7:0];
        @(posedge clock); #1;
        op_valid = 1'b0;
        if (op == 7) begin
            low = 0;
            cyc = 0;
            while (!done && cyc < 3 * N) begin
                if (!op_ready) low++;
                if (disturb) begin
                    op_valid = 1'b1; aluop = 3'd0; dst = 2'd0; use_x = 1'b1; use_y = 1'b1;
                    x = 8'($urandom); y = 8'($urandom);
                end
                @(posedge clock); #1;
                op_valid = 1'b0;
                cyc++;
            end
            check({tag, "_ready_low"}, low, N);
            check({tag, "_done"}, done, 1);
        end else begin
            check({tag, "_ready"}, op_ready, 1);
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            rd_sel = e.d;
            #1;
            check({tag, "_out"}, out, e.val);
            check({tag, "_zero"}, zero, e.z);
            check({tag, "_carry"}, carry, e.c);
        end
        if (op == 7) begin
            @(posedge clock); #1;
            check({tag, "_done_pulse"}, done, 0);
        end
    endtask

    initial begin
        int seen;
        for (int i = 0; i < R; i++) m_reg[i] = '0;

        #2;
        check("rst_ready", op_ready, 1);
        check("rst_zero", zero, 0);
        check("rst_carry", carry, 0);
        check("rst_done", done, 0);
        check_all_regs("rst", m_reg);
        @(negedge clock);
        reset_n = 1'b1;

        do_op("add", 0, 1, 200, 0, 1, 100, 0, 1, 0);
        do_op("sub", 1, 1, 5, 0, 1, 7, 0, 2, 0);
        do_op("sub_rr", 1, 0, 0, 2, 0, 0, 2, 3, 0);
        do_op("mul", 7, 1, 16, 0, 1, 17, 0, 0, 1);
        do_op("shl", 6, 1, 8'h81, 0, 1, 0, 0, 1, 0);
        do_op("xor_rr", 4, 0, 0, 1, 0, 0, 1, 1, 0);
        do_op("mul0", 7, 1, 0, 0, 1, 0, 0, 2, 0);
        do_op("mul_self", 7, 0, 0, 0, 0, 0, 0, 0, 0);

        // Aborted multiply: reset lands mid-op, r3 must not receive the product.
        do_op("pre_abort", 0, 1, 9, 0, 1, 0, 0, 3, 0);
        @(negedge clock);
        aluop = 3'd7; use_x = 1'b1; use_y = 1'b1; x = 8'd3; y = 8'd3; dst = 2'd3; op_valid = 1'b1;
        @(posedge clock); #1;
        op_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < R; i++) m_reg[i] = '0;
        #1;
        check("abort_ready", op_ready, 1);
        check("abort_zero", zero, 0);
        check("abort_carry", carry, 0);
        check("abort_done", done, 0);
        check_all_regs("abort", m_reg);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        check_all_regs("post_abort", m_reg);

        for (int k = 0; k < 40; k++) begin
            do_op($sformatf("rnd%0d", k), (k % 10 == 9) ? 7 : int'($urandom_range(0, 6)),
                  1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                  1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end
        check_all_regs("final", m_reg);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
